pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order RV pipeline. Tracks a valid/rd/rfwe/load

---
 rtl/pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the in-order RV pipeline. It keeps a small scoreboard
// (valid / rd / rf write-enable / load flag) for the NBACK stages behind decode. Stage 0 is E,
// stage NBACK-1 is W, and stage k sits k+1 stages behind decode. From that scoreboard it produces:
//   - load-use and branch-operand stalls, plus bubble insertion into stage 0;
//   - squash of the decode instruction on a redirect (flush);
//   - youngest-wins forwarding selects for the decode (branch compare) and execute operands.
// The block sits beside the stage registers and owns no datapath.
//
// Optional feature: define HAZ_PERF_EN to build the stall/flush performance counters. Without
// it, stall_cnt_o and flush_cnt_o are tied to zero.
//
// Parameters
//   NBACK   stages tracked after decode (>= 2)
//   REGA    register address width
//   LD_RDY  first stage index whose load result can be forwarded (1..NBACK-1)
//   SELW    forwarding select width, derived from NBACK
//
// Ports
//   clk_i                   rising-edge clock
//   rst_i                   synchronous active-high reset
//   ex_stall_i              external freeze: scoreboard holds and no bubble is inserted
//   flush_i                 redirect: squash the instruction currently in decode
//   d_valid_i               decode holds a real instruction
//   d_rs1a_i / d_rs2a_i     decode source register addresses
//   d_use1_i / d_use2_i     source is actually read
//   d_branch_i              decode instruction consumes its operands in decode (branch/jalr)
//   d_rda_i, d_rfwe_i       decode destination register and its write enable
//   d_load_i                decode instruction is a load
//   hz_stall_o              hold PC and the F/D register (combinational)
//   fd_hold_o               hz_stall_o | ex_stall_i
//   d_fwd1_o / d_fwd2_o     decode operand select: 0 = regfile, j = stage j result
//   e_fwd1_o / e_fwd2_o     execute operand select: 0 = regfile/latched, j = stage j result
//   e_valid_o               stage 0 holds a real instruction
//   stall_cnt_o             hazard-stall cycle count (HAZ_PERF_EN only)
//   flush_cnt_o             flush count (HAZ_PERF_EN only)

module pipe_hazard_ctrl #(
  parameter int unsigned NBACK  = 3,
  parameter int unsigned REGA   = 5,
  parameter int unsigned LD_RDY = 2,
  localparam int unsigned SELW  = $clog2(NBACK)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_stall_i,
  input  logic            flush_i,
  input  logic            d_valid_i,
  input  logic [REGA-1:0] d_rs1a_i,
  input  logic [REGA-1:0] d_rs2a_i,
  input  logic            d_use1_i,
  input  logic            d_use2_i,
  input  logic            d_branch_i,
  input  logic [REGA-1:0] d_rda_i,
  input  logic            d_rfwe_i,
  input  logic            d_load_i,
  output logic            hz_stall_o,
  output logic            fd_hold_o,
  output logic [SELW-1:0] d_fwd1_o,
  output logic [SELW-1:0] d_fwd2_o,
  output logic [SELW-1:0] e_fwd1_o,
  output logic [SELW-1:0] e_fwd2_o,
  output logic            e_valid_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  // ---------------------------------------------------------------------------------------------
  // Scoreboard state, one entry per stage behind decode
  // ---------------------------------------------------------------------------------------------
  logic [NBACK-1:0] vld_q, vld_d;
  logic [NBACK-1:0] rfwe_q, rfwe_d;
  logic [NBACK-1:0] ld_q, ld_d;
  logic [REGA-1:0]  rda_q [NBACK];
  logic [REGA-1:0]  rda_d [NBACK];

  // Source operands of the instruction in stage 0; they drive the execute forwarding selects.
  logic [REGA-1:0]  e_rs1_q, e_rs1_d;
  logic [REGA-1:0]  e_rs2_q, e_rs2_d;
  logic             e_use1_q, e_use1_d;
  logic             e_use2_q, e_use2_d;

  // Per-stage producer match vectors for the decode and execute operands
  logic [NBACK-1:0] d_m1, d_m2;
  logic [NBACK-1:0] e_m1, e_m2;

  logic             raw;
  logic             ins_vld;

  // ---------------------------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------------------------

  // Stall needed for one operand. Only the youngest matching stage counts, so the loop scans from
  // oldest to youngest and lets the younger hit overwrite the older one. A result becomes readable
  // at ready stage R (LD_RDY for loads, 1 otherwise). A non-branch consumer reaches E one stage
  // later, so it gains one stage of slack compared with a branch consumer.
  function automatic logic op_stall(input logic [NBACK-1:0] m, input logic [NBACK-1:0] ld,
                                    input logic br);
    logic st;
    int   rdy;
    st = 1'b0;
    for (int k = int'(NBACK) - 1; k >= 0; k--) begin
      if (m[k]) begin
        rdy = ld[k] ? int'(LD_RDY) : 1;
        st  = br ? (k < rdy) : (k + 1 < rdy);
      end
    end
    return st;
  endfunction

  // Youngest matching stage among 1..NBACK-1. Stage 0 is never a forwarding source.
  function automatic logic [SELW-1:0] youngest_sel(input logic [NBACK-1:0] m);
    logic [SELW-1:0] sel;
    sel = '0;
    for (int k = int'(NBACK) - 1; k >= 1; k--) begin
      if (m[k]) sel = SELW'(k);
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Producer matching. A reference to x0 never matches.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < int'(NBACK); k++) begin
      d_m1[k] = vld_q[k] & rfwe_q[k] & (rda_q[k] == d_rs1a_i) & (d_rs1a_i != '0) & d_use1_i;
      d_m2[k] = vld_q[k] & rfwe_q[k] & (rda_q[k] == d_rs2a_i) & (d_rs2a_i != '0) & d_use2_i;
      e_m1[k] = vld_q[k] & rfwe_q[k] & (rda_q[k] == e_rs1_q) & (e_rs1_q != '0) & e_use1_q &
                vld_q[0];
      e_m2[k] = vld_q[k] & rfwe_q[k] & (rda_q[k] == e_rs2_q) & (e_rs2_q != '0) & e_use2_q &
                vld_q[0];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stall, hold and forwarding outputs (all combinational from the current scoreboard)
  // ---------------------------------------------------------------------------------------------
  assign raw = op_stall(d_m1, ld_q, d_branch_i) | op_stall(d_m2, ld_q, d_branch_i);

  // Flush wins: a wrong-path instruction must not hold the front end.
  assign hz_stall_o = d_valid_i & raw & ~flush_i;
  assign fd_hold_o  = hz_stall_o | ex_stall_i;

  assign d_fwd1_o   = youngest_sel(d_m1);
  assign d_fwd2_o   = youngest_sel(d_m2);
  assign e_fwd1_o   = youngest_sel(e_m1);
  assign e_fwd2_o   = youngest_sel(e_m2);
  assign e_valid_o  = vld_q[0];

  // ---------------------------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------------------------
  assign ins_vld = d_valid_i & ~hz_stall_o & ~flush_i;

  always_comb begin
    vld_d    = vld_q;
    rfwe_d   = rfwe_q;
    ld_d     = ld_q;
    rda_d    = rda_q;
    e_rs1_d  = e_rs1_q;
    e_rs2_d  = e_rs2_q;
    e_use1_d = e_use1_q;
    e_use2_d = e_use2_q;
    if (!ex_stall_i) begin
      for (int k = 1; k < int'(NBACK); k++) begin
        vld_d[k]  = vld_q[k-1];
        rfwe_d[k] = rfwe_q[k-1];
        ld_d[k]   = ld_q[k-1];
        rda_d[k]  = rda_q[k-1];
      end
      // Stalled, flushed or empty decode slots enter stage 0 as a fully cleared bubble.
      vld_d[0]  = ins_vld;
      rfwe_d[0] = ins_vld & d_rfwe_i;
      ld_d[0]   = ins_vld & d_load_i;
      rda_d[0]  = ins_vld ? d_rda_i : '0;
      e_rs1_d   = ins_vld ? d_rs1a_i : '0;
      e_rs2_d   = ins_vld ? d_rs2a_i : '0;
      e_use1_d  = ins_vld & d_use1_i;
      e_use2_d  = ins_vld & d_use2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      rfwe_q   <= '0;
      ld_q     <= '0;
      for (int k = 0; k < int'(NBACK); k++) begin
        rda_q[k] <= '0;
      end
      e_rs1_q  <= '0;
      e_rs2_q  <= '0;
      e_use1_q <= 1'b0;
      e_use2_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rfwe_q   <= rfwe_d;
      ld_q     <= ld_d;
      rda_q    <= rda_d;
      e_rs1_q  <= e_rs1_d;
      e_rs2_q  <= e_rs2_d;
      e_use1_q <= e_use1_d;
      e_use2_q <= e_use2_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------------------------
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Only cycles lost to hazards count; cycles frozen by ex_stall are charged elsewhere.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz_stall_o && !ex_stall_i) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i)                   flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (NBACK=3, REGA=5, LD_RDY=2).
// Each table row holds one cycle of decode-side inputs and the combinational outputs expected
// before the next clock edge. Rows run back to back, so the scoreboard carries over between rows.

module tb_pipe_hazard_ctrl;

  localparam int SELW = 2;

`ifdef HAZ_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            ex_stall, flush, d_valid;
  logic [4:0]      d_rs1a, d_rs2a, d_rda;
  logic            d_use1, d_use2, d_branch, d_rfwe, d_load;
  logic            hz_stall, fd_hold, e_valid;
  logic [SELW-1:0] d_fwd1, d_fwd2, e_fwd1, e_fwd2;
  logic [31:0]     stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .NBACK (3),
    .REGA  (5),
    .LD_RDY(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ex_stall_i (ex_stall),
    .flush_i    (flush),
    .d_valid_i  (d_valid),
    .d_rs1a_i   (d_rs1a),
    .d_rs2a_i   (d_rs2a),
    .d_use1_i   (d_use1),
    .d_use2_i   (d_use2),
    .d_branch_i (d_branch),
    .d_rda_i    (d_rda),
    .d_rfwe_i   (d_rfwe),
    .d_load_i   (d_load),
    .hz_stall_o (hz_stall),
    .fd_hold_o  (fd_hold),
    .d_fwd1_o   (d_fwd1),
    .d_fwd2_o   (d_fwd2),
    .e_fwd1_o   (e_fwd1),
    .e_fwd2_o   (e_fwd2),
    .e_valid_o  (e_valid),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ex, fl, dv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2, br;
    logic [4:0] rd;
    logic       we, ld;
    logic       hz, fdh;
    logic [1:0] df1, df2, ef1, ef2;
    logic       ev;
    logic       dfdc;  // decode selects not checked on this row
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  function automatic vec_t mk(input logic ex, input logic fl, input logic dv,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic br,
                              input logic [4:0] rd, input logic we, input logic ld,
                              input logic hz, input logic fdh,
                              input logic [1:0] df1, input logic [1:0] df2,
                              input logic [1:0] ef1, input logic [1:0] ef2,
                              input logic ev, input logic dfdc);
    vec_t v;
    v.ex = ex; v.fl = fl; v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.br = br; v.rd = rd; v.we = we; v.ld = ld; v.hz = hz; v.fdh = fdh; v.df1 = df1;
    v.df2 = df2; v.ef1 = ef1; v.ef2 = ef2; v.ev = ev; v.dfdc = dfdc;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_stall = v.ex; flush = v.fl; d_valid = v.dv;
    d_rs1a = v.rs1; d_use1 = v.u1; d_rs2a = v.rs2; d_use2 = v.u2;
    d_branch = v.br; d_rda = v.rd; d_rfwe = v.we; d_load = v.ld;
  endtask

  task automatic idle_inputs();
    ex_stall = 0; flush = 0; d_valid = 0; d_rs1a = 0; d_use1 = 0; d_rs2a = 0; d_use2 = 0;
    d_branch = 0; d_rda = 0; d_rfwe = 0; d_load = 0;
  endtask

  initial begin
    //              ex fl dv rs1 u1 rs2 u2 br rd we ld   hz fh df1 df2 ef1 ef2 ev dc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // reset state
    vecs[1]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 5, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0); // lw x5
    vecs[2]  = mk(0, 0, 1, 5, 1, 1, 1, 0, 6, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0); // add x6,x5,x1
    vecs[3]  = mk(0, 0, 1, 5, 1, 1, 1, 0, 6, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0); // retry
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 0, 1, 0); // E: x5 from W
    vecs[5]  = mk(0, 0, 1, 2, 1, 3, 1, 0, 5, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0); // add x5
    vecs[6]  = mk(0, 0, 1, 5, 1, 5, 1, 0, 7, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0); // add x7,x5,x5
    vecs[7]  = mk(0, 0, 1, 7, 1, 0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 1, 1, 1, 0); // beq x7,x0
    vecs[8]  = mk(0, 0, 1, 7, 1, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0); // beq retry
    vecs[9]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 5, 1, 0,   0, 0, 0, 0, 2, 0, 1, 0); // A: add x5
    vecs[10] = mk(0, 0, 1, 1, 1, 0, 0, 0, 5, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0); // B: add x5
    vecs[11] = mk(0, 0, 1, 5, 1, 0, 0, 0, 8, 1, 0,   0, 0, 0, 0, 0, 0, 1, 1); // C: reads x5
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0); // youngest = 1
    vecs[13] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0); // writes x0
    vecs[14] = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0); // branch on x0
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0); // E reads x0
    vecs[16] = mk(0, 0, 1, 1, 1, 0, 0, 0, 9, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0); // lw x9
    vecs[17] = mk(0, 1, 1, 9, 1, 0, 0, 0, 10, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0); // use + flush
    vecs[18] = mk(1, 0, 1, 9, 1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0); // frozen
    vecs[19] = mk(1, 0, 1, 9, 1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 1, 9, 1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 9, 1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0); // thawed
    vecs[22] = mk(0, 0, 1, 9, 1, 0, 0, 1, 0, 0, 0,   0, 0, 2, 0, 0, 0, 0, 0); // load at W
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #1;
      chk("hz_stall", i, 32'(hz_stall), 32'(vecs[i].hz));
      chk("fd_hold", i, 32'(fd_hold), 32'(vecs[i].fdh));
      if (!vecs[i].dfdc) begin
        chk("d_fwd1", i, 32'(d_fwd1), 32'(vecs[i].df1));
        chk("d_fwd2", i, 32'(d_fwd2), 32'(vecs[i].df2));
      end
      chk("e_fwd1", i, 32'(e_fwd1), 32'(vecs[i].ef1));
      chk("e_fwd2", i, 32'(e_fwd2), 32'(vecs[i].ef2));
      chk("e_valid", i, 32'(e_valid), 32'(vecs[i].ev));
      chk("stall_cnt", i, stall_cnt, Perf ? exp_stall : 32'd0);
      chk("flush_cnt", i, flush_cnt, Perf ? exp_flush : 32'd0);
      @(posedge clk);
      if (vecs[i].hz && !vecs[i].ex) exp_stall++;
      if (vecs[i].fl) exp_flush++;
      @(negedge clk);
    end

    // Mid-stream reset: put a load into stage 0, then reset while frozen and flushing.
    d_valid = 1; d_rs1a = 1; d_use1 = 1; d_rs2a = 0; d_use2 = 0; d_branch = 0;
    d_rda = 5; d_rfwe = 1; d_load = 1; ex_stall = 0; flush = 0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_e_valid", 100, 32'(e_valid), 32'd1);
    rst = 1; ex_stall = 1; flush = 1;
    #1;
    chk("rst_cycle_fd_hold", 101, 32'(fd_hold), 32'd1);
    chk("rst_cycle_hz_stall", 101, 32'(hz_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0; ex_stall = 0; flush = 0;
    // A branch on x5 would stall if the old load had survived the reset.
    d_valid = 1; d_rs1a = 5; d_use1 = 1; d_branch = 1; d_rda = 0; d_rfwe = 0; d_load = 0;
    #1;
    chk("post_rst_e_valid", 102, 32'(e_valid), 32'd0);
    chk("post_rst_hz_stall", 102, 32'(hz_stall), 32'd0);
    chk("post_rst_d_fwd1", 102, 32'(d_fwd1), 32'd0);
    chk("post_rst_stall_cnt", 102, stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", 102, flush_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
